// File: rtl/baud_gen_prog.sv
// baud_gen_prog: runtime-programmable UART oversample / bit / mid-bit tick generator.
// Latency: ticks are registered, one clk after the phase counter wraps; config applies at bit boundaries.
// Backpressure: none; ticks are free-running strobes gated only by enable and resync.
// Optional fractional divisor accumulator: define BAUD_GEN_FRAC_EN.

module baud_gen_prog #(
  parameter int DIV_INT_W        = 16,
  parameter int DIV_FRAC_W       = 4,
  parameter int OSR_W            = 5,
  parameter int DEFAULT_DIV_INT  = 325,
  parameter int DEFAULT_DIV_FRAC = 8,
  parameter int DEFAULT_OSR      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [DIV_INT_W-1:0]  cfg_div_int,
  input  logic [DIV_FRAC_W-1:0] cfg_div_frac,
  input  logic [OSR_W-1:0]      cfg_osr,
  input  logic                  cfg_load,
  output logic                  cfg_pending,
  input  logic                  resync,
  output logic                  tick_os,
  output logic                  tick_bit,
  output logic                  tick_mid,
  output logic [OSR_W-1:0]      os_idx
);

  // Smallest divisor / ratio that still leaves room for distinct mid and bit ticks.
  localparam logic [DIV_INT_W-1:0] DIV_MIN = DIV_INT_W'(2);
  localparam logic [OSR_W-1:0]     OSR_MIN = OSR_W'(4);

  function automatic logic [DIV_INT_W-1:0] clamp_div(input logic [DIV_INT_W-1:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

  function automatic logic [OSR_W-1:0] clamp_osr(input logic [OSR_W-1:0] o);
    return (o < OSR_MIN) ? OSR_MIN : o;
  endfunction

  // Active and shadow configuration
  logic [DIV_INT_W-1:0] r_div_int;
  logic [DIV_INT_W-1:0] r_sh_div_int;
  logic [OSR_W-1:0]     r_osr;
  logic [OSR_W-1:0]     r_sh_osr;
  logic                 r_pending;

  // Phase state and registered strobes
  logic [DIV_INT_W-1:0] r_os_cnt;
  logic [OSR_W-1:0]     r_os_idx;
  logic                 r_tick_os;
  logic                 r_tick_bit;
  logic                 r_tick_mid;

  logic                 w_carry;
  logic [DIV_INT_W-1:0] w_last_cnt;
  logic                 w_wrap;
  logic                 w_idx_last;
  logic [OSR_W-1:0]     w_idx_next;
  logic                 w_boundary;
  logic                 w_apply;

`ifdef BAUD_GEN_FRAC_EN
  logic [DIV_FRAC_W-1:0] r_div_frac;
  logic [DIV_FRAC_W-1:0] r_sh_div_frac;
  logic [DIV_FRAC_W-1:0] r_acc;
  logic                  r_carry;
  logic                  r_start;
  logic [DIV_FRAC_W:0]   w_sum;

  // The accumulator add happens in the first cycle of each period; its carry
  // is used straight away (a period is at least 2 clks, so no wrap can occur
  // in that cycle) and is then held for the rest of the period.
  assign w_sum   = {1'b0, r_acc} + {1'b0, r_div_frac};
  assign w_carry = r_start ? w_sum[DIV_FRAC_W] : r_carry;

  // Fractional accumulator: restarted on disable/resync, stepped once per period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_start <= 1'b1;
    end else if (!enable || resync) begin
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_start <= 1'b1;
    end else if (w_wrap) begin
      r_start <= 1'b1;
    end else if (r_start) begin
      r_acc   <= w_sum[DIV_FRAC_W-1:0];
      r_carry <= w_sum[DIV_FRAC_W];
      r_start <= 1'b0;
    end
  end

  // Fractional part of the shadow/active configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_frac    <= DIV_FRAC_W'(DEFAULT_DIV_FRAC);
      r_sh_div_frac <= '0;
    end else begin
      if (cfg_load) begin
        r_sh_div_frac <= cfg_div_frac;
      end
      if (w_apply) begin
        if (cfg_load) begin
          r_div_frac <= cfg_div_frac;
        end else if (r_pending) begin
          r_div_frac <= r_sh_div_frac;
        end
      end
    end
  end
`else
  logic w_unused_frac;

  // Integer-only build: fractional inputs have no effect.
  assign w_carry       = 1'b0;
  assign w_unused_frac = (^cfg_div_frac) ^ (DEFAULT_DIV_FRAC != 0);
`endif

  assign w_last_cnt = r_div_int - DIV_INT_W'(1) + DIV_INT_W'(w_carry);
  assign w_wrap     = enable && (r_os_cnt == w_last_cnt);
  assign w_idx_last = (r_os_idx == (r_osr - OSR_W'(1)));
  assign w_idx_next = w_idx_last ? '0 : (r_os_idx + OSR_W'(1));
  // resync overrides a coincident wrap, so it never produces a boundary
  assign w_boundary = w_wrap && !resync && w_idx_last;
  assign w_apply    = !enable || w_boundary;

  // Phase counter, oversample index and registered tick strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_os_cnt   <= '0;
      r_os_idx   <= '0;
      r_tick_os  <= 1'b0;
      r_tick_bit <= 1'b0;
      r_tick_mid <= 1'b0;
    end else if (!enable || resync) begin
      r_os_cnt   <= '0;
      r_os_idx   <= '0;
      r_tick_os  <= 1'b0;
      r_tick_bit <= 1'b0;
      r_tick_mid <= 1'b0;
    end else if (w_wrap) begin
      r_os_cnt   <= '0;
      r_os_idx   <= w_idx_next;
      r_tick_os  <= 1'b1;
      r_tick_bit <= w_idx_last;
      r_tick_mid <= (w_idx_next == (r_osr >> 1));
    end else begin
      r_os_cnt   <= r_os_cnt + DIV_INT_W'(1);
      r_tick_os  <= 1'b0;
      r_tick_bit <= 1'b0;
      r_tick_mid <= 1'b0;
    end
  end

  // Shadow capture and activation at bit boundaries or while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_int    <= DIV_INT_W'(DEFAULT_DIV_INT);
      r_osr        <= OSR_W'(DEFAULT_OSR);
      r_sh_div_int <= '0;
      r_sh_osr     <= '0;
      r_pending    <= 1'b0;
    end else begin
      if (cfg_load) begin
        r_sh_div_int <= cfg_div_int;
        r_sh_osr     <= cfg_osr;
      end
      if (w_apply) begin
        // a load landing on the boundary bypasses the shadow entirely
        if (cfg_load) begin
          r_div_int <= clamp_div(cfg_div_int);
          r_osr     <= clamp_osr(cfg_osr);
        end else if (r_pending) begin
          r_div_int <= clamp_div(r_sh_div_int);
          r_osr     <= clamp_osr(r_sh_osr);
        end
        r_pending <= 1'b0;
      end else if (cfg_load) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign cfg_pending = r_pending;
  assign tick_os     = r_tick_os;
  assign tick_bit    = r_tick_bit;
  assign tick_mid    = r_tick_mid;
  assign os_idx      = r_os_idx;

endmodule
